io_out_fsm: RTL and testbench

IO_OUT_FSM -- requirements
Module: io_out_fsm

---
 rtl/io_pkg.sv | 7 +
 rtl/io_adder.sv | 10 +
 rtl/io_lane_reg.sv | 37 +++
 rtl/io_out_fsm.sv | 81 ++++++++
 tb/tb_io_out_fsm.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared lane geometry and state encoding for the result-output FSMs.
package io_pkg;
  localparam int LANES = 4;
  localparam int LANE_W = 8;
  localparam int BUS_W = LANES * LANE_W;
  typedef enum logic [1:0] {IDLE, COLLECT, SEND, DONE} state_e;
endpackage

// File: rtl/io_adder.sv
// io_adder: plain wrapping W-bit adder.
module io_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a + b;
endmodule

// File: rtl/io_lane_reg.sv
// io_lane_reg: one byte lane's captured/finished flags and latched byte.
module io_lane_reg
  import io_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_cap,
  input  logic              clr_all,
  input  logic              take,
  input  logic              eob,
  input  logic [LANE_W-1:0] din,
  output logic              cap_q,
  output logic              fin_q,
  output logic              cap_d,
  output logic              fin_d,
  output logic [LANE_W-1:0] byte_o
);
  logic [LANE_W-1:0] byte_q, byte_d;
  always_comb begin
    cap_d = (clr_cap || clr_all) ? 1'b0 : cap_q | take;
    fin_d = clr_all ? 1'b0 : fin_q | (take & eob);
    byte_d = take ? din : byte_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      cap_q <= 1'b0;
      fin_q <= 1'b0;
      byte_q <= '0;
    end else begin
      cap_q <= cap_d;
      fin_q <= fin_d;
      byte_q <= byte_d;
    end
  end
  // a lane with nothing captured (finished or not) contributes zero to the word
  assign byte_o = cap_q ? byte_q : '0;
endmodule

// File: rtl/io_out_fsm.sv
// io_out_fsm: packs per-lane result bytes into bus words and hands them to the host.
module io_out_fsm #(
  parameter int LANES = io_pkg::LANES,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [io_pkg::LANE_W-1:0] in1,
  input  logic [io_pkg::LANE_W-1:0] in2,
  input  logic [io_pkg::LANE_W-1:0] in3,
  input  logic [io_pkg::LANE_W-1:0] in4,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES-1:0]        in_eob,
  output logic [LANES-1:0]        take,
  output logic [io_pkg::BUS_W-1:0] data,
  output logic                    data_en,
  output logic                    irq,
  input  logic                    ack,
  output logic                    done,
  output logic [CNT_W-1:0]        word_count
);
  import io_pkg::*;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [LANES-1:0] cap_q, fin_q, cap_d, fin_d;
  logic [BUS_W-1:0] in_bus, word;
  logic restart, acked;
  assign in_bus = {in4, in3, in2, in1};
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    io_lane_reg u_lane (
      .clk    (clk),
      .reset  (reset),
      .clr_cap(acked),
      .clr_all(restart),
      .take   (take[i]),
      .eob    (in_eob[i]),
      .din    (in_bus[i*LANE_W +: LANE_W]),
      .cap_q  (cap_q[i]),
      .fin_q  (fin_q[i]),
      .cap_d  (cap_d[i]),
      .fin_d  (fin_d[i]),
      .byte_o (word[i*LANE_W +: LANE_W])
    );
  end
  io_adder #(.W(CNT_W)) u_add (
    .a(cnt_q),
    .b(CNT_W'(1)),
    .y(cnt_inc)
  );
  // transitions out of COLLECT look at next-cycle flags so int rises right after the last take
  always_comb begin
    restart = start && (state_q == IDLE || state_q == DONE);
    acked = ack && (state_q == SEND);
    take = (state_q == COLLECT) ? in_valid & ~cap_q & ~fin_q : '0;
    cnt_d = restart ? '0 : acked ? cnt_inc : cnt_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? COLLECT : IDLE;
      COLLECT: state_d = (&fin_d && !(|cap_d)) ? DONE : (&(cap_d | fin_d)) ? SEND : COLLECT;
      SEND:    state_d = !ack ? SEND : (&fin_q) ? DONE : COLLECT;
      DONE:    state_d = start ? COLLECT : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // irq is the host "int" line; int is a reserved word
  assign data_en = state_q == SEND;
  assign irq = state_q == SEND;
  assign done = state_q == DONE;
  assign data = data_en ? word : '0;
  assign word_count = cnt_q;
endmodule

// File: tb/tb_io_out_fsm.sv
// tb_io_out_fsm: directed scenarios plus randomized lane streams against a word-level model.
module tb_io_out_fsm;
  logic clk = 0, reset = 0, start = 0, ack = 0;
  logic [7:0] lb[4];
  logic [7:0] in1, in2, in3, in4;
  logic [3:0] in_valid = 0, in_eob = 0, take;
  logic [31:0] data;
  logic data_en, irq, done;
  logic [15:0] word_count;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;
  assign in1 = lb[0];
  assign in2 = lb[1];
  assign in3 = lb[2];
  assign in4 = lb[3];

  io_out_fsm dut (
    .clk(clk), .reset(reset), .start(start), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .in_valid(in_valid), .in_eob(in_eob), .take(take), .data(data), .data_en(data_en),
    .irq(irq), .ack(ack), .done(done), .word_count(word_count)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    reset = 0; start = 0; ack = 0; in_valid = 0; in_eob = 0;
    lb = '{8'h00, 8'h00, 8'h00, 8'h00};
    tick; tick;
    reset = 1;
  endtask

  task automatic start_run;
    start = 1;
    tick;
    start = 0;
  endtask

  task automatic test_reset;
    reset = 0; start = 0; ack = 1; in_valid = 4'hF; in_eob = 4'hF;
    lb = '{8'h12, 8'h34, 8'h56, 8'h78};
    tick; tick;
    #1;
    tests++;
    if ({take, data, data_en, irq, done, word_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got take=%h data=%h en=%b int=%b done=%b wc=%0d want all zero", take, data, data_en, irq, done, word_count);
    end
    reset = 1; ack = 0;
    tick; #1;
    tests++;
    if (take !== 4'h0) begin fails++; $display("FAIL idle_take: got %h want 0", take); end
    in_valid = 0; in_eob = 0;
  endtask

  task automatic test_all_lanes;
    do_reset; start_run;
    lb = '{8'h11, 8'h22, 8'h33, 8'h44}; in_valid = 4'hF; #1;
    tests++;
    if (take !== 4'hF) begin fails++; $display("FAIL all_take: got %h want f", take); end
    tick; in_valid = 0; #1;
    tests++;
    if (take !== 4'h0) begin fails++; $display("FAIL all_take_once: got %h want 0", take); end
    tests++;
    if (irq !== 1'b1 || data_en !== 1'b1) begin fails++; $display("FAIL all_int: got int=%b en=%b want 1 1", irq, data_en); end
    tests++;
    if (data !== 32'h44332211) begin fails++; $display("FAIL all_data: got %h want 44332211", data); end
    ack = 1; tick; ack = 0; #1;
    tests++;
    if (irq !== 1'b0 || data !== 32'h0) begin fails++; $display("FAIL all_after_ack: got int=%b data=%h want 0 0", irq, data); end
    tests++;
    if (word_count !== 16'd1) begin fails++; $display("FAIL all_count: got %0d want 1", word_count); end
  endtask

  task automatic test_staggered;
    lb = '{8'h51, 8'h52, 8'h53, 8'h54}; in_valid = 4'b1011; #1;
    tests++;
    if (take !== 4'b1011) begin fails++; $display("FAIL stag_first: got %b want 1011", take); end
    tick;
    for (int c = 0; c < 2; c++) begin
      lb = '{8'hEE, 8'hEE, 8'hEE, 8'hEE}; in_valid = 4'b1011; #1;
      tests++;
      if (take !== 4'b0000 || irq !== 1'b0) begin fails++; $display("FAIL stag_wait%0d: got take=%b int=%b want 0000 0", c, take, irq); end
      tick;
    end
    lb[2] = 8'h53; in_valid = 4'b0100; #1;
    tests++;
    if (take !== 4'b0100) begin fails++; $display("FAIL stag_late: got %b want 0100", take); end
    tick; in_valid = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++;
      if (irq !== 1'b1 || data !== 32'h54535251) begin fails++; $display("FAIL stag_hold%0d: got int=%b data=%h want 1 54535251", c, irq, data); end
      tick;
    end
    ack = 1; tick; ack = 0; #1;
    tests++;
    if (irq !== 1'b0 || word_count !== 16'd2) begin fails++; $display("FAIL stag_ack: got int=%b wc=%0d want 0 2", irq, word_count); end
  endtask

  task automatic test_eob_lane0;
    do_reset; start_run;
    lb = '{8'hAA, 8'h01, 8'h02, 8'h03}; in_valid = 4'hF; in_eob = 4'b0001; tick;
    in_valid = 0; in_eob = 0; #1;
    tests++;
    if (data !== 32'h030201AA) begin fails++; $display("FAIL eob_word0: got %h want 030201aa", data); end
    ack = 1; tick; ack = 0;
    lb = '{8'hBB, 8'h11, 8'h12, 8'h13}; in_valid = 4'hF; #1;
    tests++;
    if (take !== 4'b1110) begin fails++; $display("FAIL eob_take1: got %b want 1110", take); end
    tick; in_valid = 0; #1;
    tests++;
    if (data !== 32'h13121100) begin fails++; $display("FAIL eob_word1: got %h want 13121100", data); end
    ack = 1; tick; ack = 0;
    lb = '{8'hCC, 8'h21, 8'h22, 8'h23}; in_valid = 4'hF; in_eob = 4'b1110; #1;
    tests++;
    if (take !== 4'b1110) begin fails++; $display("FAIL eob_take2: got %b want 1110", take); end
    tick; in_valid = 0; in_eob = 0; #1;
    tests++;
    if (data !== 32'h23222100) begin fails++; $display("FAIL eob_word2: got %h want 23222100", data); end
    ack = 1; tick; ack = 0; #1;
    tests++;
    if (done !== 1'b1 || word_count !== 16'd3) begin fails++; $display("FAIL eob_done: got done=%b wc=%0d want 1 3", done, word_count); end
  endtask

  task automatic test_all_eob;
    do_reset; start_run;
    lb = '{8'h01, 8'h02, 8'h03, 8'h04}; in_valid = 4'hF; in_eob = 4'hF; tick;
    in_valid = 0; in_eob = 0; #1;
    tests++;
    if (data !== 32'h04030201) begin fails++; $display("FAIL alleob_word: got %h want 04030201", data); end
    ack = 1; tick; ack = 0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 4'hF; #1;
      tests++;
      if (done !== 1'b1 || irq !== 1'b0 || take !== 4'h0 || word_count !== 16'd1) begin
        fails++; $display("FAIL alleob_done%0d: got done=%b int=%b take=%h wc=%0d want 1 0 0 1", c, done, irq, take, word_count);
      end
      tick;
    end
    in_valid = 0;
    start_run; #1;
    tests++;
    if (done !== 1'b0 || word_count !== 16'd0) begin fails++; $display("FAIL alleob_restart: got done=%b wc=%0d want 0 0", done, word_count); end
  endtask

  task automatic test_reset_in_send;
    do_reset; start_run;
    lb = '{8'h77, 8'h00, 8'h00, 8'h00}; in_valid = 4'b0001; ack = 1; tick;
    ack = 0; lb[0] = 8'h78; start = 1; #1;
    tests++;
    if (take !== 4'b0000) begin fails++; $display("FAIL rs_captured: got %b want 0000", take); end
    tick; start = 0; #1;
    tests++;
    if (take !== 4'b0000 || word_count !== 16'd0) begin fails++; $display("FAIL rs_start_ignored: got take=%b wc=%0d want 0000 0", take, word_count); end
    lb = '{8'h00, 8'h66, 8'h55, 8'h44}; in_valid = 4'b1110; tick;
    in_valid = 0; #1;
    tests++;
    if (irq !== 1'b1 || data !== 32'h44556677) begin fails++; $display("FAIL rs_send: got int=%b data=%h want 1 44556677", irq, data); end
    reset = 0; ack = 1; tick; reset = 1; ack = 0; #1;
    tests++;
    if ({data, data_en, irq, done, word_count} !== '0) begin
      fails++; $display("FAIL rs_reset: got data=%h en=%b int=%b done=%b wc=%0d want all zero", data, data_en, irq, done, word_count);
    end
    ack = 1; in_valid = 4'hF; #1;
    tests++;
    if (take !== 4'h0) begin fails++; $display("FAIL rs_idle_take: got %h want 0", take); end
    tick; ack = 0; in_valid = 0; #1;
    tests++;
    if (word_count !== 16'd0 || irq !== 1'b0) begin fails++; $display("FAIL rs_idle_ack: got wc=%0d int=%b want 0 0", word_count, irq); end
  endtask

  // Model: lane i streams bytes s_i[0..L_i-1], last one flagged eob; word k carries
  // s_i[k] in lane i, or 00 once lane i has run out. Exactly max(L_i) words are sent.
  task automatic test_random;
    logic [7:0] q[4][$];
    logic [31:0] exp_w[$];
    int nw, wk, dly, len[4];
    bit seen;
    for (int it = 0; it < 25; it++) begin
      do_reset;
      nw = 0;
      for (int i = 0; i < 4; i++) begin
        q[i] = {};
        len[i] = $urandom_range(1, 4);
        for (int k = 0; k < len[i]; k++) q[i].push_back(8'($urandom));
        if (len[i] > nw) nw = len[i];
      end
      exp_w = {};
      for (int k = 0; k < nw; k++) begin
        logic [31:0] w;
        w = 0;
        for (int i = 0; i < 4; i++) if (k < len[i]) w[i*8 +: 8] = q[i][k];
        exp_w.push_back(w);
      end
      wk = 0; seen = 0; dly = $urandom_range(0, 4);
      start_run;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
        tests++;
        if (word_count !== 16'(wk)) begin fails++; $display("FAIL rnd%0d_count: got %0d want %0d", it, word_count, wk); end
        if (irq) begin
          if (!seen) begin
            tests++;
            if (wk >= nw || data !== exp_w[wk]) begin
              fails++; $display("FAIL rnd%0d_word%0d: got %h want %h", it, wk, data, (wk < nw) ? exp_w[wk] : 32'hx);
            end
          end
          seen = 1;
          ack = (dly == 0);
          if (dly > 0) dly--;
        end else ack = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < 4; i++) begin
          if (q[i].size() > 0) begin
            in_valid[i] = 1'($urandom);
            lb[i] = q[i][0];
            in_eob[i] = q[i].size() == 1;
          end else begin
            in_valid[i] = 0;
            lb[i] = 8'($urandom);
            in_eob[i] = 1'($urandom);
          end
        end
        #1;
        tests++;
        if ((take & ~in_valid) !== 4'h0 || ((irq || done) && take !== 4'h0)) begin
          fails++; $display("FAIL rnd%0d_take: got take=%b valid=%b int=%b", it, take, in_valid, irq);
        end
        for (int i = 0; i < 4; i++) if (take[i] && q[i].size() > 0) void'(q[i].pop_front());
        if (ack && irq) begin
          wk++; seen = 0; dly = $urandom_range(0, 4);
        end
        tick;
      end
      ack = 0; in_valid = 0; in_eob = 0; #1;
      tests++;
      if (done !== 1'b1 || wk != nw || word_count !== 16'(nw)) begin
        fails++; $display("FAIL rnd%0d_end: got done=%b words=%0d wc=%0d want 1 %0d %0d", it, done, wk, word_count, nw, nw);
      end
      tests++;
      if (q[0].size() + q[1].size() + q[2].size() + q[3].size() != 0) begin
        fails++; $display("FAIL rnd%0d_left: got %0d bytes untaken want 0", it, q[0].size() + q[1].size() + q[2].size() + q[3].size());
      end
    end
  endtask

  initial begin
    lb = '{8'h00, 8'h00, 8'h00, 8'h00};
    test_reset;
    test_all_lanes;
    test_staggered;
    test_eob_lane0;
    test_all_eob;
    test_reset_in_send;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
